pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Parametrised successor to the single-cycle program counter. It generates instruction-memory fetch addresses through a request/acknowledge handshake and supports the following:
- sequential +4 stepping;
- PC-relative branches and register-based absolute jumps (JALR style);
- pipeline stall;
- detection of misaligned redirect targets.

It sits between the decode/branch logic and the instruction memory in the RV32 core.

Parameters:
ADDR_W, 10, PC/address width in bits (2^ADDR_W byte address space)
OFFSET_W, 20, immediate offset width (sign-extended to ADDR_W)
RESET_ADDR, 0, PC value loaded on reset (must be 4-byte aligned)
TRAP_ADDR, 16, trap vector; used only with PC_TRAP_VEC_EN

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC; deassert imem_req while high
branch  in  1  taken PC-relative redirect: target = pc_out + sext(offset)
jump  in  1  taken absolute redirect: target = (jump_base + sext(offset)) with bit0 cleared
offset  in  OFFSET_W  signed immediate
jump_base  in  ADDR_W  register operand for jump
imem_ack  in  1  memory has returned the word at imem_addr
pc_out  out  ADDR_W  current PC
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  equals pc_out
instr_valid  out  1  one-cycle pulse; the fetch at pc_out completed
flush  out  1  one-cycle pulse on an accepted redirect
misalign_err  out  1  one-cycle pulse on a target with bit1 set

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_out=RESET_ADDR; state=BOOT.
  - imem_req, instr_valid, flush and misalign_err are all 0.
  - Assertion mid-fetch aborts the fetch immediately, with no ack dependence.
- FSM states: BOOT, FETCH, HOLD, TRAP.
- BOOT: entered in the first cycle after reset is released. imem_req=0. Moves to FETCH next cycle unconditionally.
- FETCH: imem_req=1. Evaluated each clk edge with this priority:
  1. branch or jump (jump wins if both are high): compute the target.
     - If target[1]=1: pulse misalign_err, leave pc_out unchanged, go to TRAP.
     - Otherwise: pc_out<=target, pulse flush. Any ack in the same cycle is discarded (no instr_valid). Stay in FETCH.
  2. stall: pc_out is held. If imem_ack arrives in this cycle, instr_valid still pulses but pc_out is not advanced. Go to HOLD.
  3. imem_ack: pulse instr_valid and set pc_out<=pc_out+4.
  4. Otherwise: wait, holding pc_out and imem_req.
- HOLD: imem_req=0 and pc_out is held.
  - Redirects are still accepted, with the same rules as FETCH.
  - Return to FETCH on the first cycle stall=0.
- TRAP: imem_req=0 and pc_out is frozen. The only exit is reset.
- Arithmetic:
  - offset is sign-extended to max(OFFSET_W, ADDR_W), then truncated to ADDR_W.
  - All sums wrap modulo 2^ADDR_W. No overflow flag.
- Timing:
  - Pulse outputs are registered and appear the cycle after the causing edge.
  - Redirect-to-new-request latency is 1 cycle.
- imem_ack outside FETCH is ignored.

Optional Feature:
PC_TRAP_VEC_EN
- Defined: a misaligned target still pulses misalign_err, then sets pc_out<=TRAP_ADDR, pulses flush and stays in FETCH. The TRAP state is not synthesised.
- Undefined: behaviour is as above (TRAP halts until reset).

Decomposition:
- Package pc_pkg holds:
  - the FSM state typedef (BOOT/FETCH/HOLD/TRAP, 2-bit);
  - the PC_STEP=4 constant;
  - a sign-extension function.
- One natural sub-module, pc_target_calc: combinational branch/jump target, bit0 clear, and misalignment flag.
- The FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- Reset, release, then ack every FETCH cycle -> BOOT for 1 cycle, imem_addr sequence 0,4,8,12; instr_valid pulse on each.
- pc_out=1020, ack -> pc_out wraps to 0 (ADDR_W=10).
- pc_out=40, branch with offset=-8 (20'hFFFF8) together with ack -> pc_out=32, flush=1, instr_valid=0.
- jump with jump_base=101, offset=0 -> target=100 (bit0 cleared), accepted. jump_base=102 -> misalign_err=1, pc_out unchanged, TRAP, imem_req=0 until reset. With PC_TRAP_VEC_EN -> pc_out=16, flush=1.
- stall high for 3 cycles at pc_out=8 with ack in the first -> instr_valid once, imem_req=0 for 3 cycles, pc_out=8 throughout, fetch resumes at 8.
- Assert reset mid-wait (no ack) -> pc_out=RESET_ADDR and imem_req=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the instruction fetch PC controller.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } pc_state_t;

  localparam int PC_STEP = 4;

  // Sign-extend the low 'width' bits of val to 64 bits; callers truncate to their own width.
  function automatic logic [63:0] sext(input logic [63:0] val, input int width);
    return 64'($signed(val << (64 - width)) >>> (64 - width));
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: PC-relative branch or register-based jump (bit0 cleared),
// plus the misalignment flag on target bit1.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int OFFSET_W = 20
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [ADDR_W-1:0]   jump_base,
  input  logic                jump,
  output logic [ADDR_W-1:0]   target,
  output logic                misalign
);

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_sum;

  assign off_ext   = ADDR_W'(sext(64'(offset), OFFSET_W));
  assign br_target = pc + off_ext;
  assign jmp_sum   = jump_base + off_ext;
  // jump wins over branch when both are asserted
  assign target    = jump ? {jmp_sum[ADDR_W-1:1], 1'b0} : br_target;
  assign misalign  = target[1];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-address generator with req/ack handshake, redirects, stall and misalignment trap.
// Build option: PC_TRAP_VEC_EN vectors misaligned redirects to TRAP_ADDR instead of halting.
//
// state | meaning
// BOOT  | first cycle after reset release, no request
// FETCH | request outstanding at pc_out, advance on ack
// HOLD  | stalled, request dropped, redirects still taken
// TRAP  | misaligned redirect seen, frozen until reset
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int OFFSET_W   = 20,
  parameter int RESET_ADDR = 0,
  parameter int TRAP_ADDR  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch,
  input  logic                jump,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [ADDR_W-1:0]   jump_base,
  input  logic                imem_ack,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic                instr_valid,
  output logic                flush,
  output logic                misalign_err
);

  if ((RESET_ADDR % 4) != 0 || (TRAP_ADDR % 4) != 0) begin : g_align_check
    $error("pc_fetch_ctrl: RESET_ADDR and TRAP_ADDR must be 4-byte aligned");
  end

  pc_state_t         state;
  logic [ADDR_W-1:0] target;
  logic              misalign;
  logic              redirect;
  logic              stay_hold;

  pc_target_calc #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) u_target (
    .pc        (pc_out),
    .offset    (offset),
    .jump_base (jump_base),
    .jump      (jump),
    .target    (target),
    .misalign  (misalign)
  );

  assign redirect  = branch | jump;
  assign stay_hold = (state == HOLD) && stall;
  assign imem_addr = pc_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc_out       <= ADDR_W'(RESET_ADDR);
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      instr_valid  <= 1'b0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH, HOLD: begin
          if (redirect) begin
            if (misalign) begin
              misalign_err <= 1'b1;
`ifdef PC_TRAP_VEC_EN
              pc_out   <= ADDR_W'(TRAP_ADDR);
              flush    <= 1'b1;
              state    <= stay_hold ? HOLD : FETCH;
              imem_req <= !stay_hold;
`else
              state    <= TRAP;
              imem_req <= 1'b0;
`endif
            end else begin
              // any ack arriving with the redirect belongs to the discarded path
              pc_out   <= target;
              flush    <= 1'b1;
              state    <= stay_hold ? HOLD : FETCH;
              imem_req <= !stay_hold;
            end
          end else if (stall) begin
            instr_valid <= (state == FETCH) && imem_ack;
            state       <= HOLD;
            imem_req    <= 1'b0;
          end else if (state == HOLD) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr_valid <= 1'b1;
            pc_out      <= pc_out + ADDR_W'(PC_STEP);
          end
        end
        default: begin
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with default parameters (ADDR_W=10, OFFSET_W=20).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        jump;
  logic [19:0] offset;
  logic [9:0]  jump_base;
  logic        imem_ack;
  logic [9:0]  pc_out;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        instr_valid;
  logic        flush;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .jump         (jump),
    .offset       (offset),
    .jump_base    (jump_base),
    .imem_ack     (imem_ack),
    .pc_out       (pc_out),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr_valid  (instr_valid),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pc, req, valid, flush, misalign in one call
  task automatic chk_all(input string tag, input int pc, input bit req, input bit iv,
                         input bit fl, input bit me);
    chk({tag, ".pc"},    32'(pc_out),       32'(pc));
    chk({tag, ".addr"},  32'(imem_addr),    32'(pc));
    chk({tag, ".req"},   32'(imem_req),     32'(req));
    chk({tag, ".valid"}, 32'(instr_valid),  32'(iv));
    chk({tag, ".flush"}, 32'(flush),        32'(fl));
    chk({tag, ".mis"},   32'(misalign_err), 32'(me));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    offset = '0; jump_base = '0; imem_ack = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
    #9 reset = 1'b1;
    #1 chk_all("boot", 0, 0, 0, 0, 0);
    imem_ack = 1'b1;
    tick(); chk_all("fetch0", 0, 1, 0, 0, 0);
    tick(); chk_all("fetch4", 4, 1, 1, 0, 0);
    tick(); chk_all("fetch8", 8, 1, 1, 0, 0);
    tick(); chk_all("fetch12", 12, 1, 1, 0, 0);

    imem_ack = 1'b0; branch = 1'b1; offset = 20'd1004;
    tick(); chk_all("br1016", 1016, 1, 0, 1, 0);
    branch = 1'b0; imem_ack = 1'b1;
    tick(); chk_all("seq1020", 1020, 1, 1, 0, 0);
    tick(); chk_all("wrap0", 0, 1, 1, 0, 0);
    imem_ack = 1'b0;
    tick(); chk_all("wait0", 0, 1, 0, 0, 0);

    branch = 1'b1; offset = 20'd40;
    tick(); chk_all("br40", 40, 1, 0, 1, 0);
    offset = 20'hFFFF8; imem_ack = 1'b1;
    tick(); chk_all("brneg", 32, 1, 0, 1, 0);

    imem_ack = 1'b0; jump = 1'b1; jump_base = 10'd101; offset = 20'd0;
    tick(); chk_all("jmp_wins", 100, 1, 0, 1, 0);
    branch = 1'b0; jump_base = 10'd8;
    tick(); chk_all("jmp8", 8, 1, 0, 1, 0);
    jump = 1'b0;

    stall = 1'b1; imem_ack = 1'b1;
    tick(); chk_all("stall1", 8, 0, 1, 0, 0);
    tick(); chk_all("stall2", 8, 0, 0, 0, 0);
    tick(); chk_all("stall3", 8, 0, 0, 0, 0);
    stall = 1'b0;
    tick(); chk_all("resume", 8, 1, 0, 0, 0);
    tick(); chk_all("resume_ack", 12, 1, 1, 0, 0);

    imem_ack = 1'b0; jump = 1'b1; jump_base = 10'd102;
`ifdef PC_TRAP_VEC_EN
    tick(); chk_all("mis_vec", 16, 1, 0, 1, 1);
    jump = 1'b0;
    tick(); chk_all("mis_after", 16, 1, 0, 0, 0);
`else
    tick(); chk_all("mis_trap", 12, 0, 0, 0, 1);
    jump = 1'b0; imem_ack = 1'b1;
    tick(); chk_all("trap_hold1", 12, 0, 0, 0, 0);
    branch = 1'b1; offset = 20'd4;
    tick(); chk_all("trap_hold2", 12, 0, 0, 0, 0);
    branch = 1'b0;
`endif

    imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1 chk_all("rst_again", 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    tick(); chk_all("refetch", 0, 1, 0, 0, 0);
    branch = 1'b1; offset = 20'd40;
    tick(); chk_all("br40b", 40, 1, 0, 1, 0);
    branch = 1'b0;
    tick(); chk_all("wait40", 40, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1 chk_all("rst_mid", 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
